// File: rtl/v_mem_fill_if.sv
// Bus bundle between a memory-fill engine and its banked SRAM write ports.
// The slave side is the fill engine; the master side is the controller plus the RAM banks.
interface v_mem_fill_if #(
   parameter int N = 256,
   parameter int W = 32,
   parameter int C = 1
);
   localparam int AW = (N > 1) ? $clog2(N) : 1;

   logic          i_start;
   logic          i_abort;
   logic [1:0]    i_mode;
   logic [W-1:0]  i_fill_data;
   logic [AW-1:0] i_lo_addr;
   logic [AW-1:0] i_hi_addr;
   logic [C-1:0]  i_bank_mask;
   logic [C-1:0]  i_wready;

   logic [C-1:0]  o_wen_r;
   logic [AW-1:0] o_waddr_r;
   logic [W-1:0]  o_wdata_r;
   logic          o_busy_r;
   logic          o_done_r;
   logic [1:0]    o_status_r;

   modport master (
      output i_start, i_abort, i_mode, i_fill_data, i_lo_addr, i_hi_addr,
             i_bank_mask, i_wready,
      input  o_wen_r, o_waddr_r, o_wdata_r, o_busy_r, o_done_r, o_status_r
   );

   modport slave (
      input  i_start, i_abort, i_mode, i_fill_data, i_lo_addr, i_hi_addr,
             i_bank_mask, i_wready,
      output o_wen_r, o_waddr_r, o_wdata_r, o_busy_r, o_done_r, o_status_r
   );
endinterface

// File: rtl/v_mem_fill.sv
// Multi-bank memory initialiser: sweeps [lo, hi] across the masked banks in lockstep,
// writing a constant, incrementing or address-derived pattern under per-bank backpressure.
module v_mem_fill #(
   parameter int N         = 256,
   parameter int W         = 32,
   parameter int C         = 1,
   parameter int AUTO_INIT = 1
) (
   input logic         clk,
   input logic         arst_n,
   v_mem_fill_if.slave bus
);
   localparam int            AW        = (N > 1) ? $clog2(N) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   state_t        state,    state_nx;
   logic [1:0]    mode_q,   mode_nx;
   logic [W-1:0]  fill_q,   fill_nx;
   logic [AW-1:0] lo_q,     lo_nx;
   logic [AW-1:0] hi_q,     hi_nx;
   logic [C-1:0]  mask_q,   mask_nx;
   logic [C-1:0]  wen_q,    wen_nx;
   logic [AW-1:0] waddr_q,  waddr_nx;
   logic [W-1:0]  wdata_q,  wdata_nx;
   logic [1:0]    status_q, status_nx;

   logic          cfg_err;
   logic          all_acc;
   logic [AW-1:0] addr_inc;

   // Mode 3 is reserved and behaves like a constant fill.
   function automatic logic [W-1:0] pattern(input logic [1:0]    m,
                                            input logic [W-1:0]  f,
                                            input logic [AW-1:0] a,
                                            input logic [AW-1:0] lo);
      logic [W-1:0] res;
      case (m)
         2'd1:    res = f + W'(a - lo);
         2'd2:    res = W'(a);
         default: res = f;
      endcase
      return res;
   endfunction

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         if (AUTO_INIT != 0) state <= LOAD;
         else                state <= IDLE;
         mode_q   <= 2'd0;
         fill_q   <= '0;
         lo_q     <= '0;
         hi_q     <= LAST_ADDR;
         mask_q   <= '1;
         wen_q    <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         status_q <= 2'd0;
      end else begin
         state    <= state_nx;
         mode_q   <= mode_nx;
         fill_q   <= fill_nx;
         lo_q     <= lo_nx;
         hi_q     <= hi_nx;
         mask_q   <= mask_nx;
         wen_q    <= wen_nx;
         waddr_q  <= waddr_nx;
         wdata_q  <= wdata_nx;
         status_q <= status_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      mode_nx   = mode_q;
      fill_nx   = fill_q;
      lo_nx     = lo_q;
      hi_nx     = hi_q;
      mask_nx   = mask_q;
      wen_nx    = wen_q;
      waddr_nx  = waddr_q;
      wdata_nx  = wdata_q;
      status_nx = status_q;

      cfg_err  = (lo_q > hi_q) || (int'(hi_q) > N - 1) || (mask_q == '0);
      // A word is finished once no still-pending bank is stalled.
      all_acc  = ((wen_q & ~bus.i_wready) == '0);
      addr_inc = waddr_q + AW'(1);

      unique case (state)
         IDLE: begin
            if (bus.i_start) begin
               mode_nx   = bus.i_mode;
               fill_nx   = bus.i_fill_data;
               lo_nx     = bus.i_lo_addr;
               hi_nx     = bus.i_hi_addr;
               mask_nx   = bus.i_bank_mask;
               status_nx = 2'd0;
               state_nx  = LOAD;
            end
         end
         LOAD: begin
            if (bus.i_abort) begin
               status_nx = 2'd2;
               state_nx  = DONE;
            end else if (cfg_err) begin
               status_nx = 2'd1;
               state_nx  = DONE;
            end else begin
               waddr_nx = lo_q;
               wdata_nx = pattern(mode_q, fill_q, lo_q, lo_q);
               wen_nx   = mask_q;
               state_nx = WRITE;
            end
         end
         WRITE: begin
            wen_nx = wen_q & ~bus.i_wready;
            if (bus.i_abort) begin
               wen_nx    = '0;
               status_nx = 2'd2;
               state_nx  = DONE;
            end else if (all_acc) begin
               if (waddr_q == hi_q) begin
                  wen_nx   = '0;
                  state_nx = DONE;
               end else begin
                  waddr_nx = addr_inc;
                  wdata_nx = pattern(mode_q, fill_q, addr_inc, lo_q);
                  wen_nx   = mask_q;
               end
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign bus.o_wen_r    = wen_q;
   assign bus.o_waddr_r  = waddr_q;
   assign bus.o_wdata_r  = wdata_q;
   assign bus.o_busy_r   = (state == LOAD) || (state == WRITE);
   assign bus.o_done_r   = (state == DONE);
   assign bus.o_status_r = status_q;
endmodule

// File: tb/tb_v_mem_fill.sv
// Bench for v_mem_fill: table of directed fills, hand-written corner sequences and
// random fills, all checked against a memory image predicted from the fill rules.
module tb_v_mem_fill;
   localparam int N  = 12;
   localparam int W  = 32;
   localparam int C  = 2;
   localparam int AW = 4;

   logic clk    = 1'b0;
   logic arst_n = 1'b0;
   always #5 clk = ~clk;

   v_mem_fill_if #(.N(N), .W(W), .C(C)) bus ();

   v_mem_fill #(.N(N), .W(W), .C(C), .AUTO_INIT(1)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .bus    (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Observed memory contents and per-cell write counts, built from accepted writes.
   logic [31:0] mem      [2][16];
   int          wr_cnt   [2][16];
   logic [31:0] snap_mem [2][16];
   int          snap_cnt [2][16];

   always @(posedge clk) begin
      if (arst_n) begin
         for (int b = 0; b < 2; b++) begin
            if (bus.o_wen_r[b] && bus.i_wready[b]) begin
               mem[b][bus.o_waddr_r]    <= bus.o_wdata_r;
               wr_cnt[b][bus.o_waddr_r] <= wr_cnt[b][bus.o_waddr_r] + 1;
            end
         end
      end
   end

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] fill;
      logic [3:0]  lo;
      logic [3:0]  hi;
      logic [1:0]  mask;
      logic [1:0]  st;
      int          words;
   } vec_t;

   vec_t vt [8];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [31:0] exp_pat(input logic [1:0] m, input logic [31:0] f,
                                           input int lo, input int a);
      case (m)
         2'd1:    return f + 32'(a - lo);
         2'd2:    return 32'(a);
         default: return f;
      endcase
   endfunction

   task automatic snap();
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < 16; a++) begin
            snap_mem[b][a] = mem[b][a];
            snap_cnt[b][a] = wr_cnt[b][a];
         end
   endtask

   // Every masked cell in [lo, hi] written exactly once with its pattern; all else untouched.
   task automatic check_mem(input string nm, input logic [1:0] m, input logic [31:0] f,
                            input int lo, input int hi, input logic [1:0] mk);
      int          bad;
      bit          wrote;
      logic [31:0] e;
      bad = 0;
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < 16; a++) begin
            wrote = mk[b] && (a >= lo) && (a <= hi);
            e = wrote ? exp_pat(m, f, lo, a) : snap_mem[b][a];
            if (mem[b][a] !== e || (wr_cnt[b][a] - snap_cnt[b][a]) != (wrote ? 1 : 0)) begin
               if (bad == 0)
                  $display("%s: first bad cell bank %0d addr %0d data=%h want %h writes=%0d",
                           nm, b, a, mem[b][a], e, wr_cnt[b][a] - snap_cnt[b][a]);
               bad++;
            end
         end
      check(nm, 64'(bad), 64'd0);
   endtask

   task automatic start_fill(input logic [1:0] m, input logic [31:0] f,
                             input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                             input logic [1:0] mk);
      bus.i_mode      = m;
      bus.i_fill_data = f;
      bus.i_lo_addr   = lo;
      bus.i_hi_addr   = hi;
      bus.i_bank_mask = mk;
      bus.i_start     = 1'b1;
      tick();
      bus.i_start     = 1'b0;
   endtask

   // Returns the cycle index (relative to the start cycle) in which o_done_r is seen.
   task automatic wait_done(input int c0, input int budget, input bit rnd, output int cyc);
      cyc = c0;
      while (bus.o_done_r !== 1'b1 && cyc < budget) begin
         if (rnd) bus.i_wready = 2'($urandom_range(0, 3));
         tick();
         cyc++;
      end
      if (bus.o_done_r !== 1'b1) check("done_timeout", 64'd0, 64'd1);
      bus.i_wready = 2'b11;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cyc;
      int          ew;
      logic [1:0]  m;
      logic [31:0] f;
      logic [3:0]  lo, hi;
      logic [1:0]  mk;

      vt[0] = '{2'd1, 32'hFFFF_FFFE, 4'd4,  4'd7,  2'b11, 2'd0, 4};
      vt[1] = '{2'd0, 32'hA5A5_A5A5, 4'd0,  4'd11, 2'b01, 2'd0, 12};
      vt[2] = '{2'd2, 32'h0000_0000, 4'd3,  4'd3,  2'b10, 2'd0, 1};
      vt[3] = '{2'd3, 32'h1234_5678, 4'd10, 4'd11, 2'b11, 2'd0, 2};
      vt[4] = '{2'd0, 32'h0000_0001, 4'd9,  4'd3,  2'b11, 2'd1, 0};
      vt[5] = '{2'd0, 32'h0000_0002, 4'd0,  4'd12, 2'b11, 2'd1, 0};
      vt[6] = '{2'd1, 32'h0000_0003, 4'd2,  4'd5,  2'b00, 2'd1, 0};
      vt[7] = '{2'd1, 32'h0000_0100, 4'd0,  4'd5,  2'b11, 2'd0, 6};

      bus.i_start     = 1'b0;
      bus.i_abort     = 1'b0;
      bus.i_mode      = 2'd0;
      bus.i_fill_data = '0;
      bus.i_lo_addr   = '0;
      bus.i_hi_addr   = '0;
      bus.i_bank_mask = '0;
      bus.i_wready    = 2'b11;

      // Reset values and power-on full-range zero fill.
      tick(); tick();
      check("rst_wen",    bus.o_wen_r,    2'b00);
      check("rst_waddr",  bus.o_waddr_r,  4'd0);
      check("rst_wdata",  bus.o_wdata_r,  32'd0);
      check("rst_done",   bus.o_done_r,   1'b0);
      check("rst_status", bus.o_status_r, 2'd0);
      check("rst_busy",   bus.o_busy_r,   1'b1);
      snap();
      arst_n = 1'b1;
      tick();
      check("auto_wen",   bus.o_wen_r,   2'b11);
      check("auto_waddr", bus.o_waddr_r, 4'd0);
      wait_done(1, 100, 1'b0, cyc);
      check("auto_done_cyc", 64'(cyc), 64'(N + 1));
      check("auto_busy",     bus.o_busy_r,   1'b0);
      check("auto_status",   bus.o_status_r, 2'd0);
      tick();
      check("auto_pulse", bus.o_done_r, 1'b0);
      check_mem("auto_mem", 2'd0, 32'd0, 0, N - 1, 2'b11);

      // Directed fills with every bank ready.
      for (int i = 0; i < 8; i++) begin
         snap();
         start_fill(vt[i].mode, vt[i].fill, vt[i].lo, vt[i].hi, vt[i].mask);
         check($sformatf("v%0d_busy", i), bus.o_busy_r, 1'b1);
         wait_done(1, 60, 1'b0, cyc);
         ew = (vt[i].words > 0) ? vt[i].words + 2 : 2;
         check($sformatf("v%0d_done_cyc", i), 64'(cyc), 64'(ew));
         check($sformatf("v%0d_status", i), bus.o_status_r, vt[i].st);
         check($sformatf("v%0d_busy_end", i), bus.o_busy_r, 1'b0);
         tick();
         check($sformatf("v%0d_pulse", i), bus.o_done_r, 1'b0);
         if (vt[i].words > 0)
            check_mem($sformatf("v%0d_mem", i), vt[i].mode, vt[i].fill,
                      int'(vt[i].lo), int'(vt[i].hi), vt[i].mask);
         else
            check_mem($sformatf("v%0d_mem", i), vt[i].mode, vt[i].fill, 1, 0, 2'b00);
      end

      // Bank 1 ready only on odd cycles: each word takes two cycles.
      snap();
      start_fill(2'd1, 32'h10, 4'd0, 4'd3, 2'b11);
      for (int c = 2; c <= 9; c++) begin
         tick();
         check($sformatf("bp_wen_c%0d", c), bus.o_wen_r, (c % 2 == 0) ? 2'b11 : 2'b10);
         check($sformatf("bp_addr_c%0d", c), bus.o_waddr_r, 64'((c - 2) / 2));
         bus.i_wready = {1'(c % 2), 1'b1};
      end
      tick();
      bus.i_wready = 2'b11;
      check("bp_done",   bus.o_done_r,   1'b1);
      check("bp_status", bus.o_status_r, 2'd0);
      tick();
      check_mem("bp_mem", 2'd1, 32'h10, 0, 3, 2'b11);

      // Abort raised in the cycle the third word is accepted.
      snap();
      start_fill(2'd0, 32'hCAFE_0001, 4'd0, 4'd11, 2'b01);
      tick(); tick(); tick();
      bus.i_abort = 1'b1;
      tick();
      bus.i_abort = 1'b0;
      check("ab_wen",    bus.o_wen_r,    2'b00);
      check("ab_done",   bus.o_done_r,   1'b1);
      check("ab_status", bus.o_status_r, 2'd2);
      check("ab_busy",   bus.o_busy_r,   1'b0);
      tick();
      bus.i_abort = 1'b1;
      tick(); tick(); tick();
      bus.i_abort = 1'b0;
      check("idle_abort_busy",   bus.o_busy_r,   1'b0);
      check("idle_abort_done",   bus.o_done_r,   1'b0);
      check("idle_abort_status", bus.o_status_r, 2'd2);
      check_mem("ab_mem", 2'd0, 32'hCAFE_0001, 0, 2, 2'b01);

      // Asynchronous reset in the middle of a fill, then restart of the power-on fill.
      start_fill(2'd1, 32'd5, 4'd0, 4'd11, 2'b11);
      repeat (6) tick();
      check("ar_mid_addr", bus.o_waddr_r, 4'd5);
      #2 arst_n = 1'b0;
      #1;
      check("ar_wen",    bus.o_wen_r,    2'b00);
      check("ar_waddr",  bus.o_waddr_r,  4'd0);
      check("ar_wdata",  bus.o_wdata_r,  32'd0);
      check("ar_done",   bus.o_done_r,   1'b0);
      check("ar_status", bus.o_status_r, 2'd0);
      check("ar_busy",   bus.o_busy_r,   1'b1);
      tick(); tick();
      snap();
      arst_n = 1'b1;
      tick();
      check("ar_restart_addr", bus.o_waddr_r, 4'd0);
      check("ar_restart_wen",  bus.o_wen_r,   2'b11);
      start_fill(2'd2, 32'hFFFF_0000, 4'd3, 4'd3, 2'b01);
      wait_done(2, 100, 1'b0, cyc);
      check("ar_done_cyc", 64'(cyc), 64'(N + 1));
      check("ar_end_status", bus.o_status_r, 2'd0);
      tick();
      tick();
      check("ar_no_queued_start", bus.o_busy_r, 1'b0);
      check_mem("ar_mem", 2'd0, 32'd0, 0, N - 1, 2'b11);

      // Random fills under random per-bank backpressure.
      for (int i = 0; i < 25; i++) begin
         m  = 2'($urandom_range(0, 3));
         f  = $urandom;
         lo = 4'($urandom_range(0, N - 1));
         hi = 4'($urandom_range(int'(lo), N - 1));
         mk = 2'($urandom_range(1, 3));
         snap();
         start_fill(m, f, lo, hi, mk);
         wait_done(1, 400, 1'b1, cyc);
         check($sformatf("rnd%0d_status", i), bus.o_status_r, 2'd0);
         tick();
         check_mem($sformatf("rnd%0d_mem", i), m, f, int'(lo), int'(hi), mk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/v_mem_fill.md
# v_mem_fill

Parametrised multi-bank memory initialiser. Sweeps a programmable address window across up to C SRAM banks in lockstep, writing a constant, incrementing or address-derived pattern, with per-bank write-ready backpressure, abort and completion status. Sits beside each banked table (tag/state/data RAMs) and replaces the single-bank, zero-only, full-range post-reset clear with a block that can also scrub or re-pattern a sub-range at run time.

## Interface
- N, 256: words per bank (N >= 1); AW = max(1, $clog2(N))
- W, 32: word width
- C, 1: bank count (1..8)
- AUTO_INIT, 1: 1 = start a full-range zero fill on reset release; 0 = wait in IDLE
- clk  in  1  clock; one clock domain
- arst_n  in  1  asynchronous active-low reset
- i_start  in  1  start request; sampled in IDLE only
- i_abort  in  1  abort request; honoured in LOAD/WRITE
- i_mode  in  2  0 constant, 1 incrementing, 2 address-as-data, 3 treated as 0
- i_fill_data  in  W  constant/base data
- i_lo_addr  in  AW  first address (inclusive)
- i_hi_addr  in  AW  last address (inclusive)
- i_bank_mask  in  C  banks to write
- i_wready  in  C  per-bank write accept
- o_wen_r  out  C  per-bank write enable (pending mask)
- o_waddr_r  out  AW  write address, common to all banks
- o_wdata_r  out  W  write data, common to all banks
- o_busy_r  out  1  high in LOAD/WRITE
- o_done_r  out  1  one-cycle completion pulse
- o_status_r  out  2  0 ok, 1 config error, 2 aborted; held until next start

## Operation
- States: IDLE, LOAD, WRITE, DONE; all outputs decoded from registers, no input-to-output combinational path.
- Reset (async, arst_n low): o_wen_r=0, o_waddr_r=0, o_wdata_r=0, o_done_r=0, o_status_r=0. AUTO_INIT=1: state=LOAD, latched config = {lo=0, hi=N-1, mode 0, data 0, mask all-ones}, o_busy_r=1. AUTO_INIT=0: state=IDLE, o_busy_r=0.
- IDLE: i_start=1 -> latch mode/data/lo/hi/mask, -> LOAD. i_abort ignored. i_start outside IDLE ignored.
- LOAD: error if lo > hi, hi > N-1, or mask == 0 -> status=1, -> DONE, no writes. Else o_waddr_r=lo, o_wdata_r=pattern(lo), o_wen_r=mask, -> WRITE.
- WRITE: bank b accepts when o_wen_r[b] & i_wready[b]; accepted bits clear next cycle. When all pending bits are accepted or already clear (pending & ~i_wready == 0): if addr == hi -> DONE, o_wen_r=0; else addr+1, data=pattern(addr+1), o_wen_r reloads mask same edge (back-to-back, one word/cycle with full ready).
- Pattern: mode 0 = fill; mode 1 = fill + (addr - lo) mod 2^W; mode 2 = addr zero-extended (or truncated) to W.
- i_abort in LOAD/WRITE: -> DONE, o_wen_r=0 next cycle, status=2; writes accepted in the abort cycle count as performed. Abort beats range completion in the same cycle.
- DONE: o_done_r=1, o_busy_r=0 for exactly one cycle, status=0 unless already set; -> IDLE.
- Address never wraps: hi <= N-1 enforced in LOAD; lo == hi writes exactly one word.

## Timing
- i_start high in cycle 0 (IDLE): LOAD in cycle 1 (o_busy_r=1), first o_wen_r in cycle 2.
- k-word fill, all ready: o_wen_r high cycles 2..k+1; o_done_r in cycle k+2; IDLE in k+3, next start accepted there.
- AUTO_INIT: first write in the cycle after the first clk edge following arst_n release; o_done_r N+1 cycles after that edge's LOAD.
- Config error: LOAD cycle 1, DONE pulse cycle 2.
- Backpressure: a word holds its address/data until every masked bank accepts; banks accepting early see o_wen_r drop and do not re-write.
- arst_n mid-operation: immediate return to reset values; the interrupted fill is not resumed (AUTO_INIT restarts from 0).

## Test plan
- Reset release, N=16, C=1, AUTO_INIT=1, ready=1: 16 writes addr 0..15 data 0 on consecutive cycles, o_done_r pulse one cycle after addr 15, o_busy_r 1 -> 0, status 0.
- Mode 1, lo=4, hi=7, fill=0xFFFF_FFFE, W=32: data FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001 at addr 4..7, done at cycle 6.
- C=2, mask=2'b11, bank1 ready every other cycle, lo=0 hi=3: bank0 wen one cycle per word, bank1 wen until accepted; 4 words each, address advances only after both accept, 8 cycles of WRITE.
- Config errors lo=9 hi=3; hi=N; mask=0: no o_wen_r, done at cycle 2, status=1; next start with valid config -> status 0.
- Abort after 3rd accepted word of lo=0 hi=15: o_wen_r 0 next cycle, done pulse, status=2, exactly 3 words written; i_abort in IDLE has no effect.
- arst_n low at word 5, released: outputs at reset values asynchronously; AUTO_INIT restarts fill at addr 0; i_start during busy ignored.
